// File: rtl/conv_output_accum_ctrl_pkg.sv
// Shared definitions for the 1DCONV output accumulation sequencer:
// FSM state encoding, default geometry and datapath latencies.
package conv_output_accum_ctrl_pkg;

  localparam int NUM_BRAMS_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int PASS_W_DEF     = 8;

  // BRAM read data appears one cycle after the read address; the BRAM
  // block then registers it once more before it reaches the drain output.
  localparam int BRAM_RD_LAT = 1;
  localparam int OUT_REG_LAT = 1;
  localparam int DRAIN_LAT   = BRAM_RD_LAT + OUT_REG_LAT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_BIAS,
    ST_ACC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // A job needs 1..2**addr_width words per lane and at least one pass.
  function automatic logic cfg_is_legal(input int unsigned len,
                                        input int unsigned passes,
                                        input int unsigned addr_width);
    return (len != 0) && (len <= (32'd1 << addr_width)) && (passes != 0);
  endfunction

endpackage

// File: rtl/conv_acc_pipe_tracker.sv
// Tracks accepted systolic beats through the read (T), add (T+1) and
// write (T+2) stages of the accumulate micro-pipeline and decides when
// the next beat may be accepted without a read-after-write hazard.
module conv_acc_pipe_tracker
  import conv_output_accum_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  window,
  input  logic                  single,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  issue_clr,
  output logic                  ready,
  output logic                  s1_valid,
  output logic                  s1_clr,
  output logic                  s2_valid,
  output logic [ADDR_WIDTH-1:0] s2_addr
);

  logic [ADDR_WIDTH-1:0] s1_addr;

  // A beat in its add stage blocks acceptance (one beat per two cycles).
  // With a single-word lane the next read targets the word still being
  // written, so the write stage must also drain first.
  assign ready = window & ~s1_valid & ~(single & s2_valid);

  // Advance the T+1 / T+2 stage registers every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_clr   <= 1'b0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s1_valid <= issue;
      s1_addr  <= issue_addr;
      s1_clr   <= issue & issue_clr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
    end
  end

endmodule

// File: rtl/conv_output_accum_ctrl.sv
// Sequencer for the 16-lane output BRAM block in 1DCONV mode: optional
// bias preload, read-add-write accumulation over several systolic passes,
// then an ordered drain of every word. Only control signals pass through
// here; bias and systolic data go straight to the BRAM block.
module conv_output_accum_ctrl
  import conv_output_accum_ctrl_pkg::*;
#(
  parameter int NUM_BRAMS  = NUM_BRAMS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PASS_W     = PASS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [PASS_W-1:0]     cfg_passes,
  input  logic                  cfg_bias_en,
  input  logic                  bias_in_valid,
  output logic                  bias_in_ready,
  input  logic                  sys_valid,
  output logic                  sys_ready,
  output logic                  conv_mode,
  output logic                  ext_read_mode,
  output logic                  input_bias,
  output logic [NUM_BRAMS-1:0]  bias_ena,
  output logic [NUM_BRAMS-1:0]  bias_wea,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  output logic [ADDR_WIDTH-1:0] conv_output_addr_wr,
  output logic [ADDR_WIDTH-1:0] conv_output_addr_rd,
  output logic [NUM_BRAMS-1:0]  conv_ena_output,
  output logic [NUM_BRAMS-1:0]  conv_wea_output,
  output logic [NUM_BRAMS-1:0]  conv_enb_output,
  output logic                  conv_en_reg_adder,
  output logic                  conv_out_new_val_sign,
  output logic                  conv_output_systolic_reg_rst,
  output logic                  conv_output_adder_reg_rst,
  output logic                  conv_output_bram_dest,
  output logic                  drain_valid,
  output logic                  drain_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg
);

  // One extra bit so a full 2**ADDR_WIDTH lane length is representable.
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    len_q;
  logic [PASS_W-1:0]   passes_q;
  logic                bias_en_q;
  logic [CNT_W-1:0]    addr_cnt;
  logic [PASS_W-1:0]   pass_cnt;

  logic [CNT_W-1:0]    last_addr;
  logic                at_last;
  logic                all_issued;
  logic                acc_window;
  logic                drain_issue;
  logic                cfg_legal;
  logic                issue_clr;
  logic                pipe_ready;
  logic                sys_accept;
  logic                bias_accept;

  logic                s1_valid, s1_clr, s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;

  logic [DRAIN_LAT-1:0] dv_pipe;
  logic [DRAIN_LAT-1:0] dl_pipe;

  assign cfg_legal   = cfg_is_legal(32'(cfg_len), 32'(cfg_passes), ADDR_WIDTH);
  assign last_addr   = len_q - CNT_W'(1);
  assign at_last     = (addr_cnt == last_addr);
  assign all_issued  = (pass_cnt == passes_q);
  assign acc_window  = (state == ST_ACC) && !all_issued;
  assign drain_issue = (state == ST_DRAIN) && (addr_cnt != len_q);
  // Without a bias preload, pass 0 must ignore whatever the BRAM held.
  assign issue_clr   = !bias_en_q && (pass_cnt == '0);

  // Handshake readies are forced low while reset is held so nothing is
  // accepted (and no BRAM write is started) during an abort.
  assign sys_ready     = pipe_ready & ~rst;
  assign bias_in_ready = (state == ST_BIAS) & ~rst;
  assign sys_accept    = sys_valid & sys_ready;
  assign bias_accept   = bias_in_valid & bias_in_ready;

  assign conv_mode     = 1'b0;
  assign ext_read_mode = 1'b0;

  conv_acc_pipe_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .window     (acc_window),
    .single     (len_q == CNT_W'(1)),
    .issue      (sys_accept),
    .issue_addr (addr_cnt[ADDR_WIDTH-1:0]),
    .issue_clr  (issue_clr),
    .ready      (pipe_ready),
    .s1_valid   (s1_valid),
    .s1_clr     (s1_clr),
    .s2_valid   (s2_valid),
    .s2_addr    (s2_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default is assigned first so every path drives state_nxt
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && cfg_legal) state_nxt = ST_CLR;
      ST_CLR:   state_nxt = bias_en_q ? ST_BIAS : ST_ACC;
      ST_BIAS:  if (bias_accept && at_last) state_nxt = ST_ACC;
      // Leave only once the final beat is in its write stage.
      ST_ACC:   if (all_issued && !s1_valid) state_nxt = ST_DRAIN;
      // Finish once the last drained word has been presented.
      ST_DRAIN: if (dv_pipe[DRAIN_LAT-1] && dl_pipe[DRAIN_LAT-1]) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Configuration capture plus address and pass counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      passes_q  <= '0;
      bias_en_q <= 1'b0;
      addr_cnt  <= '0;
      pass_cnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && cfg_legal) begin
            len_q     <= cfg_len;
            passes_q  <= cfg_passes;
            bias_en_q <= cfg_bias_en;
          end
          addr_cnt <= '0;
          pass_cnt <= '0;
        end
        ST_BIAS: begin
          if (bias_accept) addr_cnt <= at_last ? '0 : addr_cnt + CNT_W'(1);
        end
        ST_ACC: begin
          if (sys_accept) begin
            if (at_last) begin
              addr_cnt <= '0;
              pass_cnt <= pass_cnt + PASS_W'(1);
            end else begin
              addr_cnt <= addr_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_issue) addr_cnt <= addr_cnt + CNT_W'(1);
        end
        ST_DONE: addr_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Drain delay line matching BRAM read latency plus the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_pipe <= '0;
      dl_pipe <= '0;
    end else begin
      dv_pipe <= {dv_pipe[DRAIN_LAT-2:0], drain_issue};
      dl_pipe <= {dl_pipe[DRAIN_LAT-2:0], drain_issue & at_last};
    end
  end

  // BRAM-block control decode; everything is quiet while reset is held.
  always_comb begin
    input_bias                   = (state == ST_BIAS);
    bias_ena                     = {NUM_BRAMS{bias_accept}};
    bias_wea                     = {NUM_BRAMS{bias_accept}};
    bias_addr                    = (state == ST_BIAS) ? addr_cnt[ADDR_WIDTH-1:0] : '0;
    conv_enb_output              = {NUM_BRAMS{sys_accept | drain_issue}};
    conv_output_addr_rd          = (sys_accept | drain_issue) ? addr_cnt[ADDR_WIDTH-1:0] : '0;
    conv_out_new_val_sign        = sys_accept;
    conv_en_reg_adder            = s1_valid;
    conv_ena_output              = {NUM_BRAMS{s2_valid}};
    conv_wea_output              = {NUM_BRAMS{s2_valid}};
    conv_output_addr_wr          = s2_valid ? s2_addr : '0;
    conv_output_systolic_reg_rst = (state == ST_CLR);
    conv_output_adder_reg_rst    = (state == ST_CLR) ||
                                   ((state == ST_ACC) && (issue_clr || s1_clr));
    conv_output_bram_dest        = (state == ST_DRAIN);
    drain_valid                  = dv_pipe[DRAIN_LAT-1];
    drain_last                   = dl_pipe[DRAIN_LAT-1];
    busy                         = (state != ST_IDLE);
    done                         = (state == ST_DONE);
    err_cfg                      = (state == ST_IDLE) && start && !cfg_legal;
    if (rst) begin
      input_bias                   = 1'b0;
      bias_ena                     = '0;
      bias_wea                     = '0;
      bias_addr                    = '0;
      conv_enb_output              = '0;
      conv_output_addr_rd          = '0;
      conv_out_new_val_sign        = 1'b0;
      conv_en_reg_adder            = 1'b0;
      conv_ena_output              = '0;
      conv_wea_output              = '0;
      conv_output_addr_wr          = '0;
      conv_output_systolic_reg_rst = 1'b1;
      conv_output_adder_reg_rst    = 1'b1;
      conv_output_bram_dest        = 1'b0;
      drain_valid                  = 1'b0;
      drain_last                   = 1'b0;
      busy                         = 1'b0;
      done                         = 1'b0;
      err_cfg                      = 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_output_accum_ctrl.sv
// Bench for conv_output_accum_ctrl: a behavioural BRAM-block model reacts
// to the controller's strobes, and drained words are scored against sums
// computed directly from the bias and systolic values that were sent.
module tb_conv_output_accum_ctrl;

  localparam int NUM_BRAMS  = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int PASS_W     = 8;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk, rst, start;
  logic [CNT_W-1:0]      cfg_len;
  logic [PASS_W-1:0]     cfg_passes;
  logic                  cfg_bias_en;
  logic                  bias_in_valid, bias_in_ready;
  logic                  sys_valid, sys_ready;
  logic                  conv_mode, ext_read_mode, input_bias;
  logic [NUM_BRAMS-1:0]  bias_ena, bias_wea;
  logic [ADDR_WIDTH-1:0] bias_addr, conv_output_addr_wr, conv_output_addr_rd;
  logic [NUM_BRAMS-1:0]  conv_ena_output, conv_wea_output, conv_enb_output;
  logic                  conv_en_reg_adder, conv_out_new_val_sign;
  logic                  conv_output_systolic_reg_rst, conv_output_adder_reg_rst;
  logic                  conv_output_bram_dest, drain_valid, drain_last;
  logic                  busy, done, err_cfg;

  logic [31:0] sys_data, bias_data;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_output_accum_ctrl #(
    .NUM_BRAMS (NUM_BRAMS), .ADDR_WIDTH (ADDR_WIDTH), .PASS_W (PASS_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start),
    .cfg_len (cfg_len), .cfg_passes (cfg_passes), .cfg_bias_en (cfg_bias_en),
    .bias_in_valid (bias_in_valid), .bias_in_ready (bias_in_ready),
    .sys_valid (sys_valid), .sys_ready (sys_ready),
    .conv_mode (conv_mode), .ext_read_mode (ext_read_mode), .input_bias (input_bias),
    .bias_ena (bias_ena), .bias_wea (bias_wea), .bias_addr (bias_addr),
    .conv_output_addr_wr (conv_output_addr_wr), .conv_output_addr_rd (conv_output_addr_rd),
    .conv_ena_output (conv_ena_output), .conv_wea_output (conv_wea_output),
    .conv_enb_output (conv_enb_output),
    .conv_en_reg_adder (conv_en_reg_adder), .conv_out_new_val_sign (conv_out_new_val_sign),
    .conv_output_systolic_reg_rst (conv_output_systolic_reg_rst),
    .conv_output_adder_reg_rst (conv_output_adder_reg_rst),
    .conv_output_bram_dest (conv_output_bram_dest),
    .drain_valid (drain_valid), .drain_last (drain_last),
    .busy (busy), .done (done), .err_cfg (err_cfg)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- BRAM block environment model ----------------
  typedef struct {
    bit bias_we; int bias_a; logic [31:0] bias_d;
    bit cap; logic [31:0] sys_d; bit sys_clr;
    bit rd; int rd_a;
    bit add; bit add_clr;
    bit we; int wr_a;
  } ctl_t;

  ctl_t        ctl;
  logic [31:0] mem [DEPTH];
  logic [31:0] sys_reg, rd_data, adder_reg, out_reg;
  int          last_wr_addr = -1;
  bit          prefill_req = 0;

  // Controls are sampled mid-cycle and applied on the following edge.
  always @(negedge clk) begin
    ctl.bias_we = bias_ena[0] & bias_wea[0];
    ctl.bias_a  = int'(bias_addr);
    ctl.bias_d  = bias_data;
    ctl.cap     = conv_out_new_val_sign;
    ctl.sys_d   = sys_data;
    ctl.sys_clr = conv_output_systolic_reg_rst;
    ctl.rd      = conv_enb_output[0];
    ctl.rd_a    = int'(conv_output_addr_rd);
    ctl.add     = conv_en_reg_adder;
    ctl.add_clr = conv_output_adder_reg_rst;
    ctl.we      = conv_ena_output[0] & conv_wea_output[0];
    ctl.wr_a    = int'(conv_output_addr_wr);
  end

  always @(posedge clk) begin
    if (prefill_req) for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD;
    if (ctl.bias_we) mem[ctl.bias_a] <= ctl.bias_d;
    if (ctl.we) begin
      mem[ctl.wr_a] <= adder_reg;
      last_wr_addr  <= ctl.wr_a;
    end
    if (ctl.sys_clr)  sys_reg <= '0;
    else if (ctl.cap) sys_reg <= ctl.sys_d;
    if (ctl.rd)  rd_data   <= mem[ctl.rd_a];
    if (ctl.add) adder_reg <= (ctl.add_clr ? 32'd0 : rd_data) + sys_reg;
    out_reg <= rd_data;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] data; bit last; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (!rst && drain_valid) begin
      if (exp_q.size() == 0) begin
        check("drain_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("drain_data", out_reg, e.data);
        check("drain_last", drain_last, e.last);
        check("drain_dest", conv_output_bram_dest, 1);
      end
    end
  end

  // Acceptance spacing: >=2 cycles normally, >=3 when a lane holds one word.
  int cyc = 0;
  int last_acc_cyc = -100;
  int spacing_len = 2;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (sys_valid && sys_ready) begin
      check("accept_spacing", ((cyc - last_acc_cyc) >= ((spacing_len == 1) ? 3 : 2)), 1);
      last_acc_cyc = cyc;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  bit stalled = 0;

  function automatic logic [31:0] gen_val(input int pattern, input bit is_bias, input int a);
    case (pattern)
      1:       gen_val = is_bias ? 32'd10 : 32'(a + 1);
      2:       gen_val = is_bias ? 32'd0  : 32'(a);
      3:       gen_val = is_bias ? 32'd0  : 32'd7;
      default: gen_val = 32'($urandom_range(0, 50000));
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the start cycle.
  task automatic pulse_start(input int len, input int passes, input bit bias_en, output bit err);
    cfg_len     = CNT_W'(len);
    cfg_passes  = PASS_W'(passes);
    cfg_bias_en = bias_en;
    start       = 1'b1;
    @(negedge clk);
    err = err_cfg;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_sys(input logic [31:0] v, input bit gaps);
    int n = 0;
    if (stalled) return;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    sys_valid = 1'b1;
    sys_data  = v;
    forever begin
      @(negedge clk);
      if (sys_ready) break;
      n++;
      if (n > 64) begin check("sys_ready_timeout", 0, 1); stalled = 1; break; end
    end
    @(posedge clk); #1;
    sys_valid = 1'b0;
    sys_data  = '0;
  endtask

  task automatic drive_bias(input logic [31:0] v, input bit gaps);
    int n = 0;
    if (stalled) return;
    if (gaps && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    bias_in_valid = 1'b1;
    bias_data     = v;
    forever begin
      @(negedge clk);
      if (bias_in_ready) break;
      n++;
      if (n > 64) begin check("bias_ready_timeout", 0, 1); stalled = 1; break; end
    end
    check("input_bias_high", input_bias, 1);
    @(posedge clk); #1;
    bias_in_valid = 1'b0;
    bias_data     = '0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_pulse", seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int len, input int passes, input bit bias_en, input int pattern,
                         input bit gaps, input bit prefill, input bit poke_busy);
    logic [31:0] bias_v[$];
    logic [31:0] sys_v[$];
    logic [31:0] sum [DEPTH];
    bit err;
    stalled = 0;
    for (int a = 0; a < len; a++) begin
      bias_v.push_back(gen_val(pattern, 1'b1, a));
      sum[a] = bias_en ? bias_v[a] : 32'd0;
    end
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < len; a++) begin
        logic [31:0] v;
        v = gen_val(pattern, 1'b0, a);
        sys_v.push_back(v);
        sum[a] = sum[a] + v;
      end
    for (int a = 0; a < len; a++) exp_q.push_back('{data: sum[a], last: (a == len - 1)});
    if (prefill) begin
      prefill_req = 1;
      @(posedge clk); #1;
      prefill_req = 0;
    end
    spacing_len = len;
    pulse_start(len, passes, bias_en, err);
    check("err_cfg_legal", err, 0);
    if (poke_busy) begin
      cfg_len = CNT_W'(2);
      start   = 1'b1;
      @(negedge clk);
      check("busy_during_job", busy, 1);
      check("start_while_busy_no_err", err_cfg, 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (bias_en) foreach (bias_v[i]) drive_bias(bias_v[i], gaps);
    foreach (sys_v[i]) drive_sys(sys_v[i], gaps);
    wait_done(len + 64);
    check("expected_drained", exp_q.size(), 0);
    check("final_write_addr", last_wr_addr, len - 1);
    exp_q.delete();
  endtask

  task automatic illegal_cfg(input int len, input int passes);
    bit err;
    pulse_start(len, passes, 1'b0, err);
    check("err_cfg_pulse", err, 1);
    @(negedge clk);
    check("err_cfg_busy", busy, 0);
    check("err_cfg_one_cycle", err_cfg, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit err;
    rst = 1; start = 0; cfg_len = '0; cfg_passes = '0; cfg_bias_en = 0;
    bias_in_valid = 0; sys_valid = 0; sys_data = '0; bias_data = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_adder_reg_rst", conv_output_adder_reg_rst, 1);
    check("rst_systolic_reg_rst", conv_output_systolic_reg_rst, 1);
    check("rst_sys_ready", sys_ready, 0);
    check("rst_bias_ready", bias_in_ready, 0);
    check("rst_ena", conv_ena_output, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_adder_reg_rst", conv_output_adder_reg_rst, 0);
    check("idle_systolic_reg_rst", conv_output_systolic_reg_rst, 0);
    check("idle_conv_mode", conv_mode, 0);
    check("idle_ext_read_mode", ext_read_mode, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Bias + one pass: 10 + {1,2,3,4}; a second start mid-job is ignored.
    run_job(4, 1, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    // No bias, three passes over a BRAM pre-filled with 0xDEAD: 3k per word.
    run_job(8, 3, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    // Single-word lane, five passes of 7.
    run_job(1, 5, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    // Full-depth lane with random valid gaps.
    run_job(1024, 2, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    illegal_cfg(0, 3);
    illegal_cfg(4, 0);
    illegal_cfg(1025, 1);

    // Abort in the middle of accumulation.
    spacing_len = 8;
    stalled = 0;
    pulse_start(8, 2, 1'b0, err);
    for (int i = 0; i < 3; i++) drive_sys(32'(i + 1), 1'b0);
    rst = 1;
    @(negedge clk);
    check("abort_rst_adder_clr", conv_output_adder_reg_rst, 1);
    check("abort_rst_wea", conv_wea_output, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ena", conv_ena_output, 0);
    check("abort_enb", conv_enb_output, 0);
    check("abort_adder_en", conv_en_reg_adder, 0);
    check("abort_sys_ready", sys_ready, 0);
    @(posedge clk); #1;
    run_job(8, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // A few random jobs.
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, 24), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
              0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
